prog_clock_divider: RTL

Multi-channel programmable clock divider for the CPU board FPGA. It replaces the single fixed divide-by-80 test clock with independent channels. Each channel has a runtime-loadable half-period, glitch-free divisor updates, and an enable. A single-step mode emits exactly one clock period per request, for stepping the CPU during bring-up. Outputs are clock-like signals plus one-cycle rising-edge strobes in the CLK_IN domain.

---
 rtl/prog_clock_divider_if.sv | 26 ++
 rtl/prog_clock_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/prog_clock_divider_if.sv
// Control and output bundle for prog_clock_divider: per-channel enables and
// step requests, the shared configuration write port, and the divided outputs.
interface prog_clock_divider_if #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 16
);
    logic [CHANNELS-1:0]  enable;
    logic [CHANNELS-1:0]  step;
    logic                 wr_en;
    logic [2:0]           wr_ch;
    logic [CNT_WIDTH-1:0] wr_half;
    logic                 wr_mode;
    logic [CHANNELS-1:0]  clk_out;
    logic [CHANNELS-1:0]  tick;
    logic [CHANNELS-1:0]  pending;

    modport master (
        output enable, step, wr_en, wr_ch, wr_half, wr_mode,
        input  clk_out, tick, pending
    );

    modport slave (
        input  enable, step, wr_en, wr_ch, wr_half, wr_mode,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor updates,
// free-run and single-step modes, and rising-edge strobes in the CLK_IN domain.
module prog_clock_divider #(
    parameter int CHANNELS   = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int RESET_HALF = 39
) (
    input  logic                 CLK_IN,
    input  logic                 RST_N,
    prog_clock_divider_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, SHOT, STOP} ch_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_state_t            state_q;
        logic [CNT_WIDTH-1:0] count_q;
        logic [CNT_WIDTH-1:0] half_q;
        logic [CNT_WIDTH-1:0] p_half_q;
        logic                 mode_q;
        logic                 p_mode_q;
        logic                 pend_q;
        logic                 clk_q;
        logic                 tick_q;
        logic                 shot_low_q;

        logic wr_hit, active, bnd, trunc, fall, rise;
        logic shot_end, real_rise, to_idle, apply;

        assign wr_hit    = bus.wr_en && (bus.wr_ch == 3'(i));
        assign active    = (state_q != IDLE);
        assign bnd       = (count_q == half_q);
        // Disabling during a low phase cuts it short; a high phase always completes.
        assign trunc     = active && !bus.enable[i] && !clk_q;
        assign fall      = active && !trunc && bnd && clk_q;
        assign rise      = active && !trunc && bnd && !clk_q;
        assign shot_end  = rise && (state_q == SHOT) && shot_low_q;
        assign real_rise = rise && !shot_end;
        assign to_idle   = trunc || (fall && !bus.enable[i]) || shot_end;
        assign apply     = pend_q && (to_idle || real_rise || !active);

        always_ff @(posedge CLK_IN or negedge RST_N) begin
            if (!RST_N) begin
                state_q    <= IDLE;
                count_q    <= '0;
                half_q     <= CNT_WIDTH'(RESET_HALF);
                p_half_q   <= CNT_WIDTH'(RESET_HALF);
                mode_q     <= 1'b0;
                p_mode_q   <= 1'b0;
                pend_q     <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
                shot_low_q <= 1'b0;
            end else begin
                tick_q <= real_rise;

                case (state_q)
                    IDLE: begin
                        count_q    <= '0;
                        clk_q      <= 1'b0;
                        shot_low_q <= 1'b0;
                        if (bus.enable[i] && !mode_q) begin
                            state_q <= RUN;
                        end else if (bus.enable[i] && mode_q && bus.step[i]) begin
                            state_q <= SHOT;
                        end
                    end
                    default: begin
                        if (to_idle) begin
                            state_q <= IDLE;
                            count_q <= '0;
                            clk_q   <= 1'b0;
                        end else if (fall) begin
                            count_q <= '0;
                            clk_q   <= 1'b0;
                            if (state_q == SHOT) begin
                                shot_low_q <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end else if (real_rise) begin
                            count_q <= '0;
                            clk_q   <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                            if (!bus.enable[i]) begin
                                state_q <= STOP;
                            end else if (state_q == STOP) begin
                                state_q <= RUN;
                            end
                        end
                    end
                endcase

                // A same-edge write lands after the apply so it waits for the next boundary.
                if (apply) begin
                    half_q <= p_half_q;
                    mode_q <= p_mode_q;
                    pend_q <= 1'b0;
                end
                if (wr_hit) begin
                    if (!active) begin
                        half_q <= bus.wr_half;
                        mode_q <= bus.wr_mode;
                        pend_q <= 1'b0;
                    end else begin
                        p_half_q <= bus.wr_half;
                        p_mode_q <= bus.wr_mode;
                        pend_q   <= 1'b1;
                    end
                end
            end
        end

        assign bus.clk_out[i] = clk_q;
        assign bus.tick[i]    = tick_q;
        assign bus.pending[i] = pend_q;
    end

endmodule
